// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide unit with valid/ready I/O.
// Optional MULDIV_SINGLE_CYCLE_MUL_EN makes MUL* ops complete in one cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic                  kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [W-1:0] ONES    = {W{1'b1}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [W-1:0]    result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  logic            a_neg, b_neg;
  logic [W-1:0]    abs_a, abs_b;
  logic            div_zero, div_ovf;
  logic [W-1:0]    special_res;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_shift, div_diff;
  logic [2*W-1:0]  div_next;

  // Sign correction on the raw magnitude result, then output half/field select.
  function automatic logic [W-1:0] select_result(input logic [2:0]     f,
                                                 input logic [2*W-1:0] full,
                                                 input logic           neg,
                                                 input logic           rneg);
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    prod = neg ? -full : full;
    quo  = neg ? -full[W-1:0] : full[W-1:0];
    rem  = rneg ? -full[2*W-1:W] : full[2*W-1:W];
    if (!f[2]) begin
      select_result = (f[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end else begin
      select_result = f[1] ? rem : quo;
    end
  endfunction

  always_comb begin
    a_neg    = rs1[W-1] & ((op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110));
    b_neg    = rs2[W-1] & ((op == 3'b001) | (op == 3'b100) | (op == 3'b110));
    abs_a    = a_neg ? -rs1 : rs1;
    abs_b    = b_neg ? -rs2 : rs2;
    div_zero = (rs2 == '0);
    div_ovf  = ~op[0] & (rs1 == MIN_VAL) & (rs2 == ONES);
    if (!op[1]) begin
      special_res = div_zero ? ONES : MIN_VAL;
    end else begin
      special_res = div_zero ? rs1 : '0;
    end
  end

  // Multiply: upper half accumulates, lower half holds the shifting multiplier.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};
  end

  // Divide: upper half is the partial remainder, lower half dividend -> quotient.
  always_comb begin
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[W]) begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  logic [2*W-1:0] fast_prod;
  always_comb begin
    fast_prod = {{W{1'b0}}, abs_a} * {{W{1'b0}}, abs_b};
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = op;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (op[2] && (div_zero || div_ovf)) begin
            result_d = special_res;
            state_d  = DONE;
          end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
          else if (!op[2]) begin
            result_d = select_result(op, fast_prod, a_neg ^ b_neg, a_neg);
            state_d  = DONE;
          end
`endif
          else begin
            state_d = CALC;
            cnt_d   = CW'(W);
            opnd_d  = op[2] ? abs_b : abs_a;
            acc_d   = {{W{1'b0}}, (op[2] ? abs_a : abs_b)};
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          result_d = select_result(op_q, acc_d, neg_q, rneg_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush overrides everything, including a same-cycle accept or finish.
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed bench with an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  rs1 = '0;
  logic [W-1:0]  rs2 = '0;
  logic          kill = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;

  int nvec = 0;
  int nfail = 0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Cycle-level compare process: model predicts in_ready/out_valid/result.
  initial begin
    bit          m_busy;
    bit          m_valid;
    int          m_left;
    logic [31:0] m_res;
    m_busy = 0; m_valid = 0; m_left = 0; m_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_valid = 0; m_left = 0;
      end else begin
        check("mon_in_ready", in_ready, !(m_busy || m_valid));
        check("mon_out_valid", out_valid, m_valid);
        if (m_valid) check("mon_result", result, m_res);
        if (kill) begin
          m_busy = 0; m_valid = 0;
        end else if (m_valid) begin
          if (out_ready) m_valid = 0;
        end else if (m_busy) begin
          m_left--;
          if (m_left == 0) begin m_busy = 0; m_valid = 1; end
        end else if (in_valid) begin
          m_res  = model(op, rs1, rs2);
          m_left = model_lat(op, rs1, rs2) - 1;
          if (m_left == 0) m_valid = 1;
          else m_busy = 1;
        end
      end
    end
  end

  // Issue one op, check literal result and latency, optionally stall the consumer.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lit,
                        input int lat_lit, input int hold);
    int n;
    check({name, "_model"}, model(f, a, b), exp_lit);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    op = f; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    check({name, "_latency"}, n, lat_lit);
    check({name, "_result"}, result, exp_lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_result"}, result, exp_lit);
      check({name, "_hold_in_ready"}, in_ready, 1'b0);
      check({name, "_hold_valid"}, out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33, 0);
    run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33, 0);
    run_op("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1, 0);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);
    run_op("mulneg", 3'd1, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, MUL_LAT, 0);
    run_op("remneg", 3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, 0);

    // Backpressure: consumer stalls five cycles after done.
    run_op("bp_div", 3'd4, 32'd1000,       32'hFFFF_FFF9, 32'hFFFF_FF72, 33, 5);

    // Kill a DIVU in cycle 10 of the operation.
    op = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    check("kill_in_ready", in_ready, 1'b1);
    check("kill_out_valid", out_valid, 1'b0);
    begin
      bit seen;
      seen = 0;
      repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
      check("kill_never_valid", seen, 1'b0);
    end
    @(posedge clk); #1;

    // kill wins over a simultaneous in_valid
    op = 3'd5; rs1 = 32'd9; rs2 = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("killacc_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    run_op("after_kill", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);

    // Asynchronous reset during CALC.
    op = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit with a width parameter. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over a valid/ready handshake on both the input and the output. It sits in the execute stage next to the combinational `alu` and receives ops decoded from funct3 when opcode is OP and funct7 is 0000001. While it is busy, the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Must be an even value of at least 8.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  operands and op are valid this cycle.
- `in_ready`  output  1  unit can accept an op. High only in IDLE.
- `op`  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  input  DATA_WIDTH  operand a (dividend / multiplicand).
- `rs2`  input  DATA_WIDTH  operand b (divisor / multiplier).
- `kill`  input  1  synchronous flush; abandons any op in flight.
- `out_valid`  output  1  `result` is valid.
- `out_ready`  input  1  consumer takes the result.
- `result`  output  DATA_WIDTH  final value; held stable while `out_valid` is high.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- IDLE:
  - An op is accepted on `in_valid & in_ready & ~kill`.
  - On accept, `op` is latched, and the absolute values of the operands are latched according to signedness:
    - signed a for MULH, MULHSU, DIV, REM;
    - signed b for MULH, DIV, REM.
  - The result-sign flag is latched.
- Special cases go from IDLE straight to DONE with a precomputed result:
  - divide by zero: DIV/DIVU give all ones; REM/REMU give `rs1`.
  - signed overflow (DIV/REM with a = MIN and b = -1): DIV gives MIN; REM gives 0.
- Every other case goes IDLE→CALC, and the iteration counter is loaded with DATA_WIDTH.
- CALC performs one bit per cycle:
  - multiply: shift-add into a 2·DATA_WIDTH accumulator.
  - divide: restoring shift-subtract, producing quotient and remainder registers.
  - When the counter reaches 0, go CALC→DONE.
- On entry to DONE, sign correction is applied:
  - MUL* negate the 2W product when the sign flag is set;
  - quotient sign is sign(a)^sign(b);
  - remainder sign is sign(a).
- DONE then selects the output: MUL gives the low half; MULH/MULHSU/MULHU give the high half; DIV/DIVU give the quotient; REM/REMU give the remainder.
- DONE→IDLE on `out_ready`.
- `kill` in any state:
  - next state is IDLE and `out_valid` is 0;
  - the result is discarded;
  - `in_valid` in the same cycle is ignored (kill wins).
- Reset puts the FSM in IDLE. `in_ready`=1, `out_valid`=0, `result`=0, and all internal registers are 0.

## Timing
- Accept in cycle 0.
- Iterative path: CALC occupies cycles 1..DATA_WIDTH, and `out_valid` rises in cycle DATA_WIDTH+1 (33 for W=32).
- Special-case path: `out_valid` rises in cycle 1.
- `out_valid` stays high until `out_valid & out_ready`. The next op can be accepted in the following cycle; there is no back-to-back accept in the DONE cycle.
- `in_ready` is registered from state, with no combinational path from `in_valid`.
- `result` and `out_valid` are registered outputs.
- `rst_n` low at any time, including mid-CALC, forces reset values immediately, without waiting for a clock edge.
- The counter is $clog2(DATA_WIDTH)+1 bits wide. All arithmetic is unsigned on magnitudes and truncated to the stated widths.

## Configuration
- `MULDIV_SINGLE_CYCLE_MUL_EN` defined:
  - MUL* ops go IDLE→DONE using a combinational 2W-bit signed/unsigned product, and `out_valid` rises in cycle 1.
  - Divides are unchanged.
- Undefined: MUL* use the iterative shift-add path with a latency of DATA_WIDTH+1.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD:
  - `result`=0xFFFFFFEB;
  - `out_valid` in cycle 33, or cycle 1 with the macro defined.
- Multiply high halves:
  - MULH 0x80000000·0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF·2 → 0xFFFFFFFF.
- Divide and remainder, `out_valid` in cycle 33:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD;
  - REM → 0xFFFFFFFF;
  - DIVU 100/7 → 14;
  - REMU → 2.
- Special cases, `out_valid` in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF;
  - REMU 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM → 0.
- Kill and backpressure:
  - DIVU with `kill` in cycle 10 → `out_valid` never rises, `in_ready`=1 in cycle 11, and a new op is accepted.
  - With `out_ready` held low for 5 cycles after done, `result` is stable and `in_ready`=0.
- Reset mid-operation: `rst_n` low at cycle 15 of CALC → immediately `out_valid`=0, `result`=0, `in_ready`=1, and the next op computes correctly.
